// File: rtl/ysyx_24110006_ifu.sv
// Instruction fetch unit: issues one read per PC, returns the instruction to
// decode as a one-cycle pulse, then waits for the next PC from writeback.
// Any misaligned PC, bus error or read timeout parks the unit in HALT until reset.
module ysyx_24110006_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          TIMEOUT  = 255
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_pc_valid,
  input  logic [31:0] i_dnpc,
  output logic        o_arvalid,
  output logic [31:0] o_araddr,
  input  logic        i_arready,
  input  logic        i_rvalid,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rresp,
  output logic        o_rready,
  output logic        o_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_fault,
  output logic [1:0]  o_fault_cause
);

  typedef enum logic [2:0] {
    S_ADDR,
    S_DATA,
    S_OUT,
    S_WAIT,
    S_HALT
  } state_t;

  // Counter wide enough to hold TIMEOUT-1; the last waiting cycle is the one
  // where the counter already shows TIMEOUT-1.
  localparam int            CW           = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_BUS      = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  state_t          state_reg,  state_next;
  logic [31:0]     pc_reg,     pc_next;
  logic [31:0]     inst_reg,   inst_next;
  logic [31:0]     pc_out_reg, pc_out_next;
  logic            fault_reg,  fault_next;
  logic [1:0]      cause_reg,  cause_next;
  logic [CW-1:0]   count_reg,  count_next;

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg  <= S_ADDR;
      pc_reg     <= RESET_PC;
      inst_reg   <= 32'h0;
      pc_out_reg <= 32'h0;
      fault_reg  <= 1'b0;
      cause_reg  <= 2'b00;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      inst_reg   <= inst_next;
      pc_out_reg <= pc_out_next;
      fault_reg  <= fault_next;
      cause_reg  <= cause_next;
      count_reg  <= count_next;
    end
  end

  // Next-state and register updates; everything holds unless a state acts on it.
  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    inst_next   = inst_reg;
    pc_out_next = pc_out_reg;
    fault_next  = fault_reg;
    cause_next  = cause_reg;
    count_next  = count_reg;
    case (state_reg)
      S_ADDR: begin
        if (i_arready) begin
          state_next = S_DATA;
          count_next = '0;
        end
      end
      S_DATA: begin
        if (i_rvalid) begin
          if (i_rresp == 2'b00) begin
            inst_next   = i_rdata;
            pc_out_next = pc_reg;
            state_next  = S_OUT;
          end else begin
            state_next = S_HALT;
            fault_next = 1'b1;
            cause_next = CAUSE_BUS;
          end
        end else if (count_reg == TIMEOUT_LAST) begin
          state_next = S_HALT;
          fault_next = 1'b1;
          cause_next = CAUSE_TIMEOUT;
        end else begin
          count_next = count_reg + CW'(1);
        end
      end
      S_OUT: begin
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (i_pc_valid) begin
          pc_next = i_dnpc;
          if (i_dnpc[1:0] != 2'b00) begin
            state_next = S_HALT;
            fault_next = 1'b1;
            cause_next = CAUSE_MISALIGN;
          end else begin
            state_next = S_ADDR;
          end
        end
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_HALT;
      end
    endcase
  end

  // Handshake outputs come from the state alone, so they are mutually exclusive.
  assign o_arvalid     = (state_reg == S_ADDR);
  assign o_rready      = (state_reg == S_DATA);
  assign o_valid       = (state_reg == S_OUT);
  assign o_araddr      = pc_reg;
  assign o_inst        = inst_reg;
  assign o_pc          = pc_out_reg;
  assign o_fault       = fault_reg;
  assign o_fault_cause = cause_reg;

endmodule

// File: tb/tb_ysyx_24110006_ifu.sv
// Directed testbench for the fetch unit: reset, normal fetches, stalls,
// ignored PC strobes, and the three fault causes.
module tb_ysyx_24110006_ifu;

  logic        i_clock;
  logic        i_reset;
  logic        i_pc_valid;
  logic [31:0] i_dnpc;
  logic        o_arvalid;
  logic [31:0] o_araddr;
  logic        i_arready;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic [1:0]  i_rresp;
  logic        o_rready;
  logic        o_valid;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic        o_fault;
  logic [1:0]  o_fault_cause;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_24110006_ifu dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_pc_valid    (i_pc_valid),
    .i_dnpc        (i_dnpc),
    .o_arvalid     (o_arvalid),
    .o_araddr      (o_araddr),
    .i_arready     (i_arready),
    .i_rvalid      (i_rvalid),
    .i_rdata       (i_rdata),
    .i_rresp       (i_rresp),
    .o_rready      (o_rready),
    .o_valid       (o_valid),
    .o_inst        (o_inst),
    .o_pc          (o_pc),
    .o_fault       (o_fault),
    .o_fault_cause (o_fault_cause)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // Advance one clock; outputs are observed and inputs driven 1ns after the edge.
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic reset_dut();
    i_reset = 1'b1; i_pc_valid = 1'b0; i_dnpc = 32'h0;
    i_arready = 1'b0; i_rvalid = 1'b0; i_rdata = 32'h0; i_rresp = 2'b00;
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  // From ADDR right after reset: immediate handshake, ends in WAIT.
  task automatic boot_fetch(input logic [31:0] data);
    i_arready = 1'b1; i_rvalid = 1'b1; i_rdata = data; i_rresp = 2'b00;
    tick();
    tick();
    i_arready = 1'b0; i_rvalid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset_dut();
    n_checks++; if (o_arvalid !== 1'b1) begin n_fail++; $display("FAIL reset_arvalid: got %b expected 1", o_arvalid); end
    n_checks++; if (o_araddr !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_araddr: got %h expected 80000000", o_araddr); end
    n_checks++; if ({o_rready, o_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_rready_valid: got %b expected 00", {o_rready, o_valid}); end
    n_checks++; if ({o_inst, o_pc} !== 64'h0) begin n_fail++; $display("FAIL reset_inst_pc: got %h expected 0", {o_inst, o_pc}); end
    n_checks++; if ({o_fault, o_fault_cause} !== 3'b000) begin n_fail++; $display("FAIL reset_fault: got %b expected 000", {o_fault, o_fault_cause}); end
    $display("reset: araddr=%h arvalid=%b", o_araddr, o_arvalid);
  endtask

  task automatic test_first_fetch();
    reset_dut();
    i_arready = 1'b1; i_rvalid = 1'b1; i_rdata = 32'h0000_0413; i_rresp = 2'b00;
    tick();
    n_checks++; if ({o_arvalid, o_rready, o_valid} !== 3'b010) begin n_fail++; $display("FAIL first_data_state: got %b expected 010", {o_arvalid, o_rready, o_valid}); end
    tick();
    n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b expected 1", o_valid); end
    n_checks++; if (o_inst !== 32'h0000_0413) begin n_fail++; $display("FAIL first_inst: got %h expected 00000413", o_inst); end
    n_checks++; if (o_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL first_pc: got %h expected 80000000", o_pc); end
    i_arready = 1'b0; i_rvalid = 1'b0;
    tick();
    n_checks++; if ({o_arvalid, o_rready, o_valid} !== 3'b000) begin n_fail++; $display("FAIL first_wait_state: got %b expected 000", {o_arvalid, o_rready, o_valid}); end
    n_checks++; if (o_inst !== 32'h0000_0413) begin n_fail++; $display("FAIL first_inst_hold: got %h expected 00000413", o_inst); end
    $display("fetch: pc=%h inst=%h", o_pc, o_inst);
  endtask

  // Delayed arready, with stray pc_valid pulses during ADDR that must not move the address.
  task automatic test_stall_addr();
    int pulses;
    pulses = 0;
    reset_dut();
    boot_fetch(32'h0000_0013);
    i_pc_valid = 1'b1; i_dnpc = 32'h8000_0004;
    tick();
    for (int k = 0; k < 3; k++) begin
      i_pc_valid = (k == 1); i_dnpc = 32'hDEAD_BEE0;
      n_checks++; if (o_arvalid !== 1'b1) begin n_fail++; $display("FAIL stall_arvalid[%0d]: got %b expected 1", k, o_arvalid); end
      n_checks++; if (o_araddr !== 32'h8000_0004) begin n_fail++; $display("FAIL stall_araddr[%0d]: got %h expected 80000004", k, o_araddr); end
      if (o_valid === 1'b1) pulses++;
      tick();
    end
    i_pc_valid = 1'b0;
    n_checks++; if (o_araddr !== 32'h8000_0004) begin n_fail++; $display("FAIL stall_araddr_final: got %h expected 80000004", o_araddr); end
    i_arready = 1'b1;
    tick();
    i_arready = 1'b0; i_rvalid = 1'b1; i_rdata = 32'h0010_0093;
    tick();
    if (o_valid === 1'b1) pulses++;
    n_checks++; if (o_pc !== 32'h8000_0004) begin n_fail++; $display("FAIL stall_pc: got %h expected 80000004", o_pc); end
    n_checks++; if (o_inst !== 32'h0010_0093) begin n_fail++; $display("FAIL stall_inst: got %h expected 00100093", o_inst); end
    i_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (o_valid === 1'b1) pulses++;
    end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL stall_pulses: got %0d expected 1", pulses); end
    $display("fetch: pc=%h inst=%h after 3-cycle arready stall", o_pc, o_inst);
  endtask

  // pc_valid at cycle N, immediate memory -> o_valid at N+3.
  task automatic test_min_latency();
    reset_dut();
    boot_fetch(32'h0000_0013);
    i_pc_valid = 1'b1; i_dnpc = 32'h8000_0008;
    i_arready = 1'b1; i_rvalid = 1'b1; i_rdata = 32'h1234_5678;
    tick();
    i_pc_valid = 1'b0;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL lat_n1: got %b expected 0", o_valid); end
    tick();
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL lat_n2: got %b expected 0", o_valid); end
    tick();
    n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL lat_n3: got %b expected 1", o_valid); end
    n_checks++; if ({o_pc, o_inst} !== {32'h8000_0008, 32'h1234_5678}) begin n_fail++; $display("FAIL lat_data: got %h expected 8000000812345678", {o_pc, o_inst}); end
    i_arready = 1'b0; i_rvalid = 1'b0;
    tick();
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL lat_n4: got %b expected 0", o_valid); end
    $display("fetch: pc=%h inst=%h min latency", o_pc, o_inst);
  endtask

  // pc_valid during DATA and OUT is ignored; only the following WAIT takes it.
  task automatic test_ignore_pc_valid();
    reset_dut();
    boot_fetch(32'h0000_0013);
    i_pc_valid = 1'b1; i_dnpc = 32'h8000_000C;
    tick();
    i_pc_valid = 1'b0; i_arready = 1'b1;
    tick();
    i_arready = 1'b0; i_pc_valid = 1'b1; i_dnpc = 32'hDEAD_BEE0;
    tick();
    n_checks++; if (o_rready !== 1'b1) begin n_fail++; $display("FAIL ign_data_hold: got %b expected 1", o_rready); end
    i_rvalid = 1'b1; i_rdata = 32'hAAAA_5555;
    tick();
    i_rvalid = 1'b0;
    n_checks++; if (o_pc !== 32'h8000_000C) begin n_fail++; $display("FAIL ign_pc: got %h expected 8000000c", o_pc); end
    n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL ign_valid: got %b expected 1", o_valid); end
    tick();
    n_checks++; if ({o_arvalid, o_valid} !== 2'b00) begin n_fail++; $display("FAIL ign_out_to_wait: got %b expected 00", {o_arvalid, o_valid}); end
    i_dnpc = 32'h8000_0010;
    tick();
    i_pc_valid = 1'b0;
    n_checks++; if (o_araddr !== 32'h8000_0010) begin n_fail++; $display("FAIL ign_next_addr: got %h expected 80000010", o_araddr); end
    $display("fetch: pc=%h inst=%h with ignored strobes", o_pc, o_inst);
  endtask

  task automatic test_bus_error();
    reset_dut();
    boot_fetch(32'h0000_0413);
    i_pc_valid = 1'b1; i_dnpc = 32'h8000_0014;
    tick();
    i_pc_valid = 1'b0; i_arready = 1'b1;
    tick();
    i_arready = 1'b0; i_rvalid = 1'b1; i_rresp = 2'b10; i_rdata = 32'hFFFF_FFFF;
    tick();
    i_rvalid = 1'b0; i_rresp = 2'b00;
    n_checks++; if ({o_fault, o_fault_cause} !== 3'b110) begin n_fail++; $display("FAIL bus_fault: got %b expected 110", {o_fault, o_fault_cause}); end
    n_checks++; if ({o_arvalid, o_rready, o_valid} !== 3'b000) begin n_fail++; $display("FAIL bus_outputs: got %b expected 000", {o_arvalid, o_rready, o_valid}); end
    n_checks++; if (o_inst !== 32'h0000_0413) begin n_fail++; $display("FAIL bus_inst: got %h expected 00000413", o_inst); end
    i_pc_valid = 1'b1; i_dnpc = 32'h8000_0020; i_arready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if ({o_arvalid, o_rready, o_valid, o_fault} !== 4'b0001) begin n_fail++; $display("FAIL bus_halt[%0d]: got %b expected 0001", k, {o_arvalid, o_rready, o_valid, o_fault}); end
    end
    i_pc_valid = 1'b0; i_arready = 1'b0;
    $display("bus error: fault=%b cause=%b", o_fault, o_fault_cause);
  endtask

  task automatic test_misaligned();
    reset_dut();
    boot_fetch(32'h0000_0013);
    i_pc_valid = 1'b1; i_dnpc = 32'h8000_0002;
    tick();
    i_pc_valid = 1'b0; i_arready = 1'b1;
    n_checks++; if ({o_fault, o_fault_cause} !== 3'b101) begin n_fail++; $display("FAIL mis_fault: got %b expected 101", {o_fault, o_fault_cause}); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (o_arvalid !== 1'b0) begin n_fail++; $display("FAIL mis_arvalid[%0d]: got %b expected 0", k, o_arvalid); end
      tick();
    end
    i_arready = 1'b0;
    n_checks++; if (o_inst !== 32'h0000_0013) begin n_fail++; $display("FAIL mis_inst: got %h expected 00000013", o_inst); end
    $display("misaligned: fault=%b cause=%b", o_fault, o_fault_cause);
  endtask

  // 254 silent DATA cycles keep waiting; the 255th faults. Reset then restarts at RESET_PC.
  task automatic test_timeout();
    reset_dut();
    boot_fetch(32'h0000_0013);
    i_pc_valid = 1'b1; i_dnpc = 32'h8000_0004;
    tick();
    i_pc_valid = 1'b0; i_arready = 1'b1;
    tick();
    i_arready = 1'b0;
    repeat (254) tick();
    n_checks++; if ({o_fault, o_rready} !== 2'b01) begin n_fail++; $display("FAIL to_before: got %b expected 01", {o_fault, o_rready}); end
    tick();
    n_checks++; if ({o_fault, o_fault_cause} !== 3'b111) begin n_fail++; $display("FAIL to_fault: got %b expected 111", {o_fault, o_fault_cause}); end
    n_checks++; if (o_rready !== 1'b0) begin n_fail++; $display("FAIL to_rready: got %b expected 0", o_rready); end
    $display("timeout: fault=%b cause=%b", o_fault, o_fault_cause);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    n_checks++; if ({o_arvalid, o_araddr} !== {1'b1, 32'h8000_0000}) begin n_fail++; $display("FAIL to_restart: got %h expected 180000000", {o_arvalid, o_araddr}); end
    n_checks++; if ({o_fault, o_fault_cause} !== 3'b000) begin n_fail++; $display("FAIL to_clear: got %b expected 000", {o_fault, o_fault_cause}); end
    i_arready = 1'b1; i_rvalid = 1'b1; i_rdata = 32'h0000_0513;
    tick();
    tick();
    i_arready = 1'b0; i_rvalid = 1'b0;
    n_checks++; if ({o_valid, o_pc, o_inst} !== {1'b1, 32'h8000_0000, 32'h0000_0513}) begin n_fail++; $display("FAIL to_refetch: got %h expected 18000000000000513", {o_valid, o_pc, o_inst}); end
    $display("fetch: pc=%h inst=%h after timeout reset", o_pc, o_inst);
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall_addr();
    test_min_latency();
    test_ignore_pc_valid();
    test_bus_error();
    test_misaligned();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
